fft_stage_ctrl: RTL and testbench

// - Sequencer for an in-place radix-2 DIT FFT built on one pipelined butterfly (3-cycle latency).
// - Walks LOG2N stages of N/2 butterflies: issues RAM read addresses (p,q), twiddle ROM index,

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_addr_gen.sv | 33 +++
 rtl/fft_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT stage sequencer.
package fft_pkg;

  localparam int LOG2N_DEF = 6;
  localparam int BF_LAT    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Read-to-write-back distance: RAM/ROM read latency plus butterfly latency.
  function automatic int pipe_lat(input int rd_lat);
    return rd_lat + BF_LAT;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage s, butterfly k) -> (p, q, tw_idx).
module fft_addr_gen #(
  parameter int LOG2N = 6
) (
  input  logic [LOG2N-1:0] s,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] p,
  output logic [LOG2N-1:0] q,
  output logic [LOG2N-2:0] tw_idx
);

  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
  localparam logic [LOG2N-1:0] SH_TOP = LOG2N'(LOG2N - 1);

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] g;
  logic [LOG2N-1:0] tw_full;

  // Split k into group g and in-group offset j; p is the lower leg, q sits half above.
  always_comb begin
    k_ext   = {1'b0, k};
    half    = ONE << s;
    j       = k_ext & (half - ONE);
    g       = k_ext >> s;
    p       = (g << (s + ONE)) | j;
    q       = p | half;
    tw_full = j << (SH_TOP - s);
    tw_idx  = tw_full[LOG2N-2:0];
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for an in-place radix-2 DIT FFT around one pipelined butterfly.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing one butterfly read per cycle, k = 0..N/2-1
//   DRAIN | rd_en held low for L cycles so stage writes land before next reads
//   DONE  | one-cycle done pulse, then back to IDLE
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_p,
  output logic [LOG2N-1:0] rd_addr_q,
  output logic [LOG2N-2:0] tw_idx,
  output logic             bf_en,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_p,
  output logic [LOG2N-1:0] wr_addr_q
);

  localparam int L  = pipe_lat(RD_LAT);
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(L - 1);
  localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);

  state_t state, state_nxt;

  logic [LOG2N-1:0] s_q;
  logic [LOG2N-2:0] k_q;
  logic [CW-1:0]    cnt_q;

  logic [LOG2N-1:0] ag_p;
  logic [LOG2N-1:0] ag_q;
  logic [LOG2N-2:0] ag_tw;

  logic [L-1:0]     en_sr;
  logic [LOG2N-1:0] p_sr [L];
  logic [LOG2N-1:0] q_sr [L];

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s      (s_q),
    .k      (k_q),
    .p      (ag_p),
    .q      (ag_q),
    .tw_idx (ag_tw)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (k_q == '1) state_nxt = DRAIN;
      DRAIN:   if (cnt_q == CNT_LAST) state_nxt = (s_q == S_LAST) ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage, butterfly and drain counters; k wraps to 0 naturally at the end of a stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        RUN: begin
          k_q   <= k_q + 1'b1;
          cnt_q <= '0;
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (s_q != S_LAST) s_q <= s_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          s_q   <= '0;
          k_q   <= '0;
          cnt_q <= '0;
        end
      endcase
    end
  end

  // Moore outputs; read addresses are forced to 0 outside RUN so idle write-back is all-zero.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr_p = '0;
    rd_addr_q = '0;
    tw_idx    = '0;
    case (state)
      RUN: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr_p = ag_p;
        rd_addr_q = ag_q;
        tw_idx    = ag_tw;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Free-running delay lines aligning bf_en and write-back with the datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_sr <= '0;
      for (int i = 0; i < L; i++) begin
        p_sr[i] <= '0;
        q_sr[i] <= '0;
      end
    end else begin
      en_sr <= {en_sr[L-2:0], rd_en};
      p_sr[0] <= rd_addr_p;
      q_sr[0] <= rd_addr_q;
      for (int i = 1; i < L; i++) begin
        p_sr[i] <= p_sr[i-1];
        q_sr[i] <= q_sr[i-1];
      end
    end
  end

  assign stage     = s_q;
  assign bf_en     = en_sr[RD_LAT-1];
  assign wr_en     = en_sr[L-1];
  assign wr_addr_p = p_sr[L-1];
  assign wr_addr_q = q_sr[L-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: cycle-accurate schedule model for N=8,
// plus a completion-latency check on an N=64 instance.
module tb_fft_stage_ctrl;

  localparam int LG  = 3;
  localparam int NN  = 1 << LG;
  localparam int RDL = 1;
  localparam int LL  = RDL + 3;
  localparam int NC  = 40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic start6 = 1'b0;

  logic          busy, done, rd_en, bf_en, wr_en;
  logic [LG-1:0] stage, rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
  logic [LG-2:0] tw_idx;

  logic       busy6, done6, rd_en6, bf_en6, wr_en6;
  logic [5:0] stage6, rd_p6, rd_q6, wr_p6, wr_q6;
  logic [4:0] tw6;

  int total = 0;
  int bad   = 0;

  int m_rd [NC];
  int m_p  [NC];
  int m_q  [NC];
  int m_tw [NC];
  int m_st [NC];
  int m_busy [NC];
  int m_done [NC];
  int done_c;

  fft_stage_ctrl #(.LOG2N(LG), .RD_LAT(RDL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_p(rd_addr_p), .rd_addr_q(rd_addr_q), .tw_idx(tw_idx),
    .bf_en(bf_en), .wr_en(wr_en), .wr_addr_p(wr_addr_p), .wr_addr_q(wr_addr_q)
  );

  fft_stage_ctrl #(.LOG2N(6), .RD_LAT(1)) dut6 (
    .clk(clk), .rstn(rstn), .start(start6), .busy(busy6), .done(done6), .stage(stage6),
    .rd_en(rd_en6), .rd_addr_p(rd_p6), .rd_addr_q(rd_q6), .tw_idx(tw6),
    .bf_en(bf_en6), .wr_en(wr_en6), .wr_addr_p(wr_p6), .wr_addr_q(wr_q6)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected schedule indexed by cycle after start: every stage lists the pairs (p, p+half)
  // with bit s of p clear in ascending p, then L idle drain cycles, then the done cycle.
  task automatic build_model();
    int c;
    for (int i = 0; i < NC; i++) begin
      m_rd[i] = 0; m_p[i] = 0; m_q[i] = 0; m_tw[i] = 0;
      m_st[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
    c = 1;
    for (int s = 0; s < LG; s++) begin
      int half = 1 << s;
      for (int p = 0; p < NN; p++) begin
        if (((p >> s) & 1) == 0) begin
          m_rd[c] = 1; m_p[c] = p; m_q[c] = p + half;
          m_tw[c] = (p % half) * (NN / (2 * half));
          m_st[c] = s; m_busy[c] = 1;
          c++;
        end
      end
      for (int d = 0; d < LL; d++) begin
        m_st[c] = s; m_busy[c] = 1;
        c++;
      end
    end
    m_done[c] = 1;
    m_st[c]   = LG - 1;
    done_c    = c;
  endtask

  // One transform: start, then compare every cycle; optional extra start pulse and reset abort.
  task automatic run_xfer(input int extra_c, input int rst_c);
    int wi, bi;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= done_c + 5; c++) begin
      @(negedge clk);
      wi = (c >= LL) ? c - LL : 0;
      bi = (c >= RDL) ? c - RDL : 0;
      chk_val("rd_en", rd_en, m_rd[c]);
      chk_val("rd_p", rd_addr_p, m_p[c]);
      chk_val("rd_q", rd_addr_q, m_q[c]);
      chk_val("tw", tw_idx, m_tw[c]);
      chk_val("stage", stage, m_st[c]);
      chk_val("busy", busy, m_busy[c]);
      chk_val("done", done, m_done[c]);
      chk_val("bf_en", bf_en, m_rd[bi]);
      chk_val("wr_en", wr_en, m_rd[wi]);
      chk_val("wr_p", wr_addr_p, m_p[wi]);
      chk_val("wr_q", wr_addr_q, m_q[wi]);
      if (c == rst_c) begin
        start = 1'b0;
        rstn  = 1'b0;
        #1;
        chk_val("rst_rd_en", rd_en, 0);
        chk_val("rst_wr_en", wr_en, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_stage", stage, 0);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      start = (c == extra_c);
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    build_model();

    repeat (3) @(negedge clk);
    chk_val("reset_out", {busy, done, stage, rd_en, rd_addr_p, rd_addr_q, tw_idx,
                          bf_en, wr_en, wr_addr_p, wr_addr_q}, 0);
    chk_val("reset_out6", {busy6, done6, stage6, rd_en6, rd_p6, rd_q6, tw6,
                           bf_en6, wr_en6, wr_p6, wr_q6}, 0);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_val("idle_out", {busy, done, stage, rd_en, rd_addr_p, rd_addr_q, tw_idx,
                           bf_en, wr_en, wr_addr_p, wr_addr_q}, 0);
    end

    for (int r = 0; r < 8; r++) begin
      int extra, rst_at;
      extra  = -1;
      rst_at = -1;
      case (r % 4)
        1: extra = $urandom_range(1, done_c - 2);
        2: extra = done_c;
        3: rst_at = $urandom_range(1 + NN/2 + LL, 2 * (NN/2 + LL));
        default: ;
      endcase
      run_xfer(extra, rst_at);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    @(negedge clk);
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    chk_val("rd6_first", rd_en6, 1);
    n = 0;
    while (!done6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk_val("done6_lat", n, 216);
    chk_val("busy6_at_done", busy6, 0);
    chk_val("stage6_at_done", stage6, 5);
    @(negedge clk);
    chk_val("done6_pulse", done6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
